// File: rtl/score_tracker.sv
// score_tracker -- game-score producer for the dino runner.
//
// Counts one point every prescaler period while a run is active, freezes on
// collision, and derives every score-related game event in one place: BCD
// digits for the seven-segment display, the 100-point milestone pulse, the
// day/night `dark` level and the best score since reset.
//
// Optional feature macro: SCORE_SPEEDUP_EN
//   defined   : prescaler period = TICK_DIV - thousands_digit * (TICK_DIV >> 4)
//   undefined : prescaler period fixed at TICK_DIV
//
// Parameters:
//   TICK_DIV   clk cycles per point (>= 16)
//   SCORE_MAX  saturation value of the score
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   start       in   begins a run from IDLE, restarts from OVER
//   hit         in   collision; ends the run
//   game_score  out  14-bit binary score (registered)
//   score_bcd   out  four BCD digits, [15:12] thousands .. [3:0] ones
//   high_score  out  best score since reset
//   milestone   out  one-cycle pulse when the score reaches a multiple of 100
//   dark        out  night-phase level
//   run_state   out  0 = IDLE, 1 = RUN, 2 = OVER
module score_tracker #(
  parameter int TICK_DIV  = 10_000_000,
  parameter int SCORE_MAX = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        hit,
  output logic [13:0] game_score,
  output logic [15:0] score_bcd,
  output logic [13:0] high_score,
  output logic        milestone,
  output logic        dark,
  output logic [1:0]  run_state
);

  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;

  logic [PW-1:0]  presc;
  logic [13:0]    dark_base;
  logic [9:0]     mod700;      // score modulo 700, kept in lockstep with the score

  logic           clear;
  logic           count_en;
  logic           to_over;
  logic           wrap;
  logic           inc;
  logic [13:0]    score_nxt;
  logic [15:0]    bcd_nxt;
  logic [13:0]    dark_diff;

  // Ripple-carry increment of four packed BCD digits.
  function automatic logic [15:0] bcd_inc(input logic [15:0] b);
    logic [15:0] r;
    logic        c;
    r = b;
    c = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (c) begin
        if (r[4*d +: 4] == 4'd9) begin
          r[4*d +: 4] = 4'd0;
        end else begin
          r[4*d +: 4] = r[4*d +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic at_max(input logic [13:0] s);
    return (s >= 14'(SCORE_MAX));
  endfunction

  function automatic logic [13:0] max14(input logic [13:0] a, input logic [13:0] b);
    return (a > b) ? a : b;
  endfunction

  // ---- FSM: state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- FSM: next state ----
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (hit)   state_nxt = OVER;
      OVER:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- FSM: outputs / control strobes ----
  always_comb begin
    run_state = state;
    // IDLE holds everything at zero; a restart from OVER clears the run.
    clear     = (state == IDLE) || ((state == OVER) && start);
    // A hit in RUN pre-empts any prescaler wrap in the same cycle.
    count_en  = (state == RUN) && !hit;
    to_over   = (state == RUN) && hit;
  end

  // ---- prescaler wrap ----
`ifdef SCORE_SPEEDUP_EN
  logic [31:0] period;
  always_comb begin
    period = 32'(TICK_DIV) - 32'(score_bcd[15:12]) * 32'(TICK_DIV >> 4);
    wrap   = (32'(presc) == (period - 32'd1));
  end
`else
  always_comb begin
    wrap = (presc == PW'(TICK_DIV - 1));
  end
`endif

  always_comb begin
    inc       = count_en && wrap && !at_max(game_score);
    score_nxt = game_score + 14'd1;
    bcd_nxt   = bcd_inc(score_bcd);
    dark_diff = score_nxt - dark_base;
  end

  // ---- score registers: binary, BCD and all derived events share one edge ----
  always_ff @(posedge clk) begin
    if (rst) begin
      presc      <= '0;
      game_score <= '0;
      score_bcd  <= '0;
      milestone  <= 1'b0;
      dark       <= 1'b0;
      dark_base  <= '0;
      mod700     <= '0;
      high_score <= '0;
    end else begin
      milestone <= 1'b0;
      if (clear) begin
        presc      <= '0;
        game_score <= '0;
        score_bcd  <= '0;
        dark       <= 1'b0;
        dark_base  <= '0;
        mod700     <= '0;
      end else if (count_en) begin
        // The prescaler keeps running at saturation; only the events stop.
        presc <= wrap ? '0 : presc + PW'(1);
        if (inc) begin
          game_score <= score_nxt;
          score_bcd  <= bcd_nxt;
          milestone  <= (bcd_nxt[7:0] == 8'h00);
          if (mod700 == 10'd699) begin
            mod700    <= '0;
            dark      <= 1'b1;
            dark_base <= score_nxt;
          end else begin
            mod700 <= mod700 + 10'd1;
            if (dark && (dark_diff == 14'd150)) begin
              dark <= 1'b0;
            end
          end
        end
      end
      if (to_over) begin
        high_score <= max14(high_score, game_score);
      end
    end
  end

endmodule

// File: tb/tb_score_tracker.sv
// Testbench for score_tracker: directed run scenarios on two instances (full
// range and a low saturation value) with a per-cycle comparison against an
// integer-level behavioural model, plus literal checks at key points.
module tb_score_tracker;

  localparam int TD  = 16;
  localparam int MX0 = 9999;
  localparam int MX1 = 250;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic        hit   = 1'b0;

  logic [13:0] gs0, hs0, gs1, hs1;
  logic [15:0] bcd0, bcd1;
  logic        ms0, dk0, ms1, dk1;
  logic [1:0]  rs0, rs1;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  int ms_cnt0 = 0;
  int ms_cnt1 = 0;

  score_tracker #(.TICK_DIV(TD), .SCORE_MAX(MX0)) u0 (
    .clk(clk), .rst(rst), .start(start), .hit(hit),
    .game_score(gs0), .score_bcd(bcd0), .high_score(hs0),
    .milestone(ms0), .dark(dk0), .run_state(rs0)
  );

  score_tracker #(.TICK_DIV(TD), .SCORE_MAX(MX1)) u1 (
    .clk(clk), .rst(rst), .start(start), .hit(hit),
    .game_score(gs1), .score_bcd(bcd1), .high_score(hs1),
    .milestone(ms1), .dark(dk1), .run_state(rs1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s u%0d got=%0d want=%0d", nm, idx, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_state[2];
  int m_presc[2];
  int m_score[2];
  int m_dark[2];
  int m_base[2];
  int m_high[2];
  int m_ms[2];

  function automatic int mx_of(input int i);
    return (i == 0) ? MX0 : MX1;
  endfunction

  function automatic int mperiod(input int sc);
`ifdef SCORE_SPEEDUP_EN
    return TD - (sc / 1000) * (TD >> 4);
`else
    return TD + 0 * sc;
`endif
  endfunction

  function automatic int to_bcd(input int v);
    return (((v / 1000) % 10) << 12) | (((v / 100) % 10) << 8) |
           (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      m_ms[i] = 0;
      if (rst) begin
        m_state[i] = 0; m_presc[i] = 0; m_score[i] = 0;
        m_dark[i] = 0;  m_base[i] = 0;  m_high[i] = 0;
      end else begin
        case (m_state[i])
          0: if (start) begin
               m_state[i] = 1; m_presc[i] = 0; m_score[i] = 0; m_dark[i] = 0;
             end
          1: if (hit) begin
               if (m_score[i] > m_high[i]) m_high[i] = m_score[i];
               m_state[i] = 2;
             end else if (m_presc[i] == mperiod(m_score[i]) - 1) begin
               m_presc[i] = 0;
               if (m_score[i] < mx_of(i)) begin
                 m_score[i]++;
                 if (m_score[i] % 100 == 0) m_ms[i] = 1;
                 if (m_score[i] % 700 == 0) begin
                   m_dark[i] = 1;
                   m_base[i] = m_score[i];
                 end else if (m_dark[i] == 1 && m_score[i] - m_base[i] == 150) begin
                   m_dark[i] = 0;
                 end
               end
             end else begin
               m_presc[i]++;
             end
          default: if (start) begin
               m_state[i] = 1; m_presc[i] = 0; m_score[i] = 0; m_dark[i] = 0;
             end
        endcase
      end
    end
  end

  task automatic cmp_one(input int i, input int gs, input int bcd, input int hs,
                         input int ms, input int dk, input int rs);
    chk("score",     i, gs,  m_score[i]);
    chk("bcd",       i, bcd, to_bcd(m_score[i]));
    chk("high",      i, hs,  m_high[i]);
    chk("milestone", i, ms,  m_ms[i]);
    chk("dark",      i, dk,  m_dark[i]);
    chk("state",     i, rs,  m_state[i]);
  endtask

  always @(negedge clk) begin
    if (ms0) ms_cnt0++;
    if (ms1) ms_cnt1++;
    if (chk_en) begin
      cmp_one(0, int'(gs0), int'(bcd0), int'(hs0), int'(ms0), int'(dk0), int'(rs0));
      cmp_one(1, int'(gs1), int'(bcd1), int'(hs1), int'(ms1), int'(dk1), int'(rs1));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_score(input int target);
    int n;
    n = 0;
    while (int'(gs0) != target && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) chk("timeout_score", 0, int'(gs0), target);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int cnt;
    repeat (2) @(negedge clk);
    chk("rst_score", 0, int'(gs0),  0);
    chk("rst_bcd",   0, int'(bcd0), 0);
    chk("rst_high",  0, int'(hs0),  0);
    chk("rst_ms",    0, int'(ms0),  0);
    chk("rst_dark",  0, int'(dk0),  0);
    chk("rst_state", 0, int'(rs0),  0);
    rst = 1'b0;
    chk_en = 1'b1;

    // first point lands TICK_DIV edges after start is sampled
    pulse_start();
    chk("start_state", 0, int'(rs0), 1);
    cnt = 0;
    while (int'(gs0) != 1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("first_latency", 0, cnt, 16);
    chk("first_bcd", 0, int'(bcd0), 16'h0001);

    // hit coincident with the prescaler wrap at 42
    wait_score(42);
    repeat (15) @(negedge clk);
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    chk("hit_state", 0, int'(rs0), 2);
    chk("hit_score", 0, int'(gs0), 42);
    chk("hit_high",  0, int'(hs0), 42);
    pulse_start();
    chk("restart_score", 0, int'(gs0), 0);
    chk("restart_dark",  0, int'(dk0), 0);
    chk("restart_high",  0, int'(hs0), 42);
    chk("restart_state", 0, int'(rs0), 1);

    // milestone at 100 only
    wait_score(99);
    chk("ms_at_99", 0, int'(ms0), 0);
    wait_score(100);
    chk("ms_at_100", 0, int'(ms0), 1);
    chk("bcd_100",   0, int'(bcd0), 16'h0100);
    @(negedge clk);
    chk("ms_width", 0, int'(ms0), 0);
    wait_score(101);
    chk("ms_at_101", 0, int'(ms0), 0);

    // dark window opens at 700; hit inside it, dark held through OVER
    wait_score(699);
    chk("dark_699", 0, int'(dk0), 0);
    wait_score(700);
    chk("dark_700", 0, int'(dk0), 1);
    chk("bcd_700",  0, int'(bcd0), 16'h0700);
    wait_score(720);
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    chk("over_state", 0, int'(rs0), 2);
    chk("over_high",  0, int'(hs0), 720);
    repeat (20) @(negedge clk);
    chk("frozen_score", 0, int'(gs0), 720);
    chk("frozen_dark",  0, int'(dk0), 1);
    pulse_start();
    chk("restart2_score", 0, int'(gs0), 0);
    chk("restart2_dark",  0, int'(dk0), 0);
    chk("restart2_high",  0, int'(hs0), 720);

    // dark window closes at 850; saturated instance holds at 250
    wait_score(849);
    chk("dark_849", 0, int'(dk0), 1);
    wait_score(850);
    chk("dark_850", 0, int'(dk0), 0);
    chk("bcd_850",  0, int'(bcd0), 16'h0850);
    chk("ms_count", 0, ms_cnt0, 15);
    chk("sat_ms_count", 1, ms_cnt1, 4);
    chk("sat_score", 1, int'(gs1), 250);
    chk("sat_bcd",   1, int'(bcd1), 16'h0250);
    chk("sat_high",  1, int'(hs1), 250);
    chk("sat_state", 1, int'(rs1), 1);

    // reset mid-run clears everything, high score included
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_score", 0, int'(gs0),  0);
    chk("mid_rst_bcd",   0, int'(bcd0), 0);
    chk("mid_rst_high",  0, int'(hs0),  0);
    chk("mid_rst_dark",  0, int'(dk0),  0);
    chk("mid_rst_state", 0, int'(rs0),  0);
    chk("mid_rst_high1", 1, int'(hs1),  0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/score_tracker.md
# score_tracker

Game-score producer for the dino runner. It counts points while the run is active and freezes on collision. It exports the 14-bit binary score plus BCD digits for the seven-segment display, a 100-point milestone pulse and the day/night `dark` level. Display and colour-fade logic consume these signals, so this block is the sole owner of score-derived game events.

## Interface
Parameters:
- `TICK_DIV`, default 10_000_000: `clk` cycles per point. Range ≥16.
- `SCORE_MAX`, default 9999: saturation value.

Ports:
- `clk`  in  1  system clock (100 MHz).
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  level, sampled each cycle; begins or restarts a run.
- `hit`  in  1  level; collision detected.
- `game_score`  out  14  binary score, registered.
- `score_bcd`  out  16  four BCD digits [15:12]=thousands … [3:0]=ones.
- `high_score`  out  14  best score since reset.
- `milestone`  out  1  one-cycle pulse.
- `dark`  out  1  night-phase level.
- `run_state`  out  2  0=IDLE, 1=RUN, 2=OVER.

## Operation
- FSM states:
  - IDLE: counters held at 0. `start` → RUN.
  - RUN: prescaler counts 0..TICK_DIV-1. On its wrap, the score increments by 1. `hit` → OVER.
  - OVER: everything frozen. `start` → RUN with score, BCD, prescaler and `dark` cleared on the transition edge.
- Saturation: at `SCORE_MAX` the score holds. The prescaler keeps running; no further events fire.
- BCD: maintained incrementally in lockstep with the binary score using ripple-carry digit increments. No divider. `score_bcd` always equals the decimal form of `game_score`.
- Milestone: fires on the edge where the new score is a nonzero multiple of 100, i.e. new BCD low two digits = 00.
- Dark:
  - Set when the new score is a nonzero multiple of 700. The set edge also latches `dark_base` = new score.
  - Cleared on the edge where the new score − `dark_base` = 150.
  - Multiples of 700 are 700 apart, so windows never overlap. The 9800 window clears at 9950.
  - Held through OVER. Cleared in IDLE and on restart.
- High score: on the RUN→OVER edge, `high_score` ← max(`high_score`, `game_score`).
- Simultaneous events:
  - `hit` and prescaler wrap in the same cycle: `hit` wins. No increment, no milestone, no dark change.
  - `start` while in RUN is ignored.
- Widths: the 14-bit score covers 9999. The dark difference is computed in 14 bits and is non-negative by construction.

## Timing
- Reset values: `game_score`=0, `score_bcd`=0, `high_score`=0, `milestone`=0, `dark`=0, `run_state`=0. Prescaler is 0.
- `start` sampled high in IDLE at edge N: `run_state`=1 after edge N. The first increment lands on edge N+TICK_DIV.
- `game_score`, `score_bcd`, `milestone` and `dark` all update on the same edge. Consumers see one consistent value per cycle.
- `milestone` is high for exactly one `clk` cycle after the increment edge.
- `hit` sampled at edge M in RUN: `run_state`=2 and `high_score` are updated after edge M. The score equals its value before edge M.
- `rst` mid-run returns every register to its reset value on the next edge, including `high_score`.

## Configuration
- `SCORE_SPEEDUP_EN` defined: the effective prescaler period is TICK_DIV − thousands_digit × (TICK_DIV>>4). The new period takes effect from the wrap following the thousands-digit change.
- `SCORE_SPEEDUP_EN` undefined: the period is fixed at TICK_DIV. The thousands digit is unused by the prescaler.

## Test plan
- `TICK_DIV`=16, reset, pulse `start` → `run_state`=1. After 16 cycles `game_score`=1, `score_bcd`=16'h0001.
- Run to score 100 → `milestone` high for exactly 1 cycle on the edge where `score_bcd`=16'h0100. No pulse at 99 or 101.
- Run to 700 → `dark`=1 on the same edge as `game_score`=700. `dark`=0 on the edge where `game_score`=850. `dark` stays 1 at 849.
- `hit` asserted on the same cycle as a prescaler wrap at score 42 → `run_state`=2, `game_score`=42, `high_score`=42. Then `start` → score 0, `dark`=0, `high_score` stays 42.
- Force the run to 9999 (small `TICK_DIV`) → score holds 9999 with no milestone; `dark` cleared at 9950. With `SCORE_SPEEDUP_EN` and `TICK_DIV`=64, the interval between increments at score ≥1000 is 60 cycles.
- Assert `rst` mid-run at score 300 with `high_score`=500 → all outputs 0 on the next edge, `run_state`=0.
